// File: rtl/mipi_csi_pkg.sv
// Shared definitions for the CSI-2 frame controller: short-packet codes,
// frame sequencer states and sticky error bit positions.
package mipi_csi_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hB8;
    localparam logic [7:0] DT_FRAME_START = 8'h00;
    localparam logic [7:0] DT_FRAME_END   = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_FS = 3'd1,
        ST_FRAME   = 3'd2,
        ST_LINE    = 3'd3,
        ST_DROP    = 3'd4
    } frame_state_e;

    localparam int ERR_FE_NO_FS    = 0;
    localparam int ERR_FS_IN_FRAME = 1;
    localparam int ERR_LINE_COUNT  = 2;
    localparam int ERR_LINE_LEN    = 3;

endpackage

// File: rtl/mipi_csi_rx_frame_ctrl_16b2lane_if.sv
// Bundle of the frame controller's stream, decoder and framing signals.
// Signal suffixes are from the controller's point of view (_i into it).
// Handshake: there is no backpressure; a beat is consumed on every rising
// clk_i edge where data_valid_i is high, and the decoder sees it only in
// cycles where dec_enable_o is high.
interface mipi_csi_rx_frame_ctrl_16b2lane_if;
    import mipi_csi_pkg::*;

    logic         enable_i;
    logic         data_valid_i;
    logic [31:0]  data_i;
    logic         dec_output_valid_i;
    logic [15:0]  dec_packet_length_i;
    logic [15:0]  expected_lines_i;
    logic         error_clear_i;
    logic         dec_enable_o;
    logic         frame_valid_o;
    logic         line_valid_o;
    logic         frame_start_o;
    logic         frame_end_o;
    logic [15:0]  line_count_o;
    logic [15:0]  frame_count_o;
    logic [3:0]   error_o;
    frame_state_e dbg_state_o;

    // Stimulus side: lane aligner, decoder and control.
    modport master (
        output enable_i, data_valid_i, data_i, dec_output_valid_i,
               dec_packet_length_i, expected_lines_i, error_clear_i,
        input  dec_enable_o, frame_valid_o, line_valid_o, frame_start_o,
               frame_end_o, line_count_o, frame_count_o, error_o, dbg_state_o
    );

    // Frame controller side.
    modport slave (
        input  enable_i, data_valid_i, data_i, dec_output_valid_i,
               dec_packet_length_i, expected_lines_i, error_clear_i,
        output dec_enable_o, frame_valid_o, line_valid_o, frame_start_o,
               frame_end_o, line_count_o, frame_count_o, error_o, dbg_state_o
    );

endinterface

// File: rtl/mipi_csi_short_pkt_detect.sv
// Combinational decode of Frame Start / Frame End short packets from the
// first two bytes of a lane-aligned beat.
module mipi_csi_short_pkt_detect
    import mipi_csi_pkg::*;
(
    input  logic        data_valid_i,
    input  logic [15:0] data_i,
    output logic        fs_o,
    output logic        fe_o
);

    logic sync_hit;

    // Sync byte in lane0 byte0, data type in the following byte.
    always_comb begin
        sync_hit = data_valid_i && (data_i[7:0] == SYNC_BYTE);
        fs_o     = sync_hit && (data_i[15:8] == DT_FRAME_START);
        fe_o     = sync_hit && (data_i[15:8] == DT_FRAME_END);
    end

endmodule

// File: rtl/mipi_csi_rx_frame_ctrl_16b2lane.sv
// Frame-level sequencer for the 2-lane 16-bit-gear CSI-2 receive path.
// Optional feature macro: MIPI_CSI_FRAME_CTRL_LEN_CHECK_EN enables the
// per-frame line-length consistency check (first line's length is latched).
module mipi_csi_rx_frame_ctrl_16b2lane
    import mipi_csi_pkg::*;
#(
    parameter logic [15:0] MAX_LINES = 16'd4096
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    mipi_csi_rx_frame_ctrl_16b2lane_if.slave    bus
);

    frame_state_e state_q, state_d;
    logic         frame_valid_q, frame_valid_d;
    logic         line_valid_q, line_valid_d;
    logic         frame_start_q, frame_start_d;
    logic         frame_end_q, frame_end_d;
    logic [15:0]  line_count_q, line_count_d;
    logic [15:0]  frame_count_q, frame_count_d;
    logic [3:0]   error_q, error_d, err_set;
    logic         dov_prev_q, dv_prev_q;
    logic         dec_en;
    logic         is_fs, is_fe, dov_rise, line_end;
`ifdef MIPI_CSI_FRAME_CTRL_LEN_CHECK_EN
    logic [15:0]  len_q, len_d;
`endif

    mipi_csi_short_pkt_detect u_short_pkt (
        .data_valid_i (bus.data_valid_i),
        .data_i       (bus.data_i[15:0]),
        .fs_o         (is_fs),
        .fe_o         (is_fe)
    );

    // Next-state, counters, error collection and output pulse generation.
    always_comb begin
        state_d       = state_q;
        line_count_d  = line_count_q;
        frame_count_d = frame_count_q;
        err_set       = '0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        line_valid_d  = 1'b0;
        dec_en        = 1'b0;
`ifdef MIPI_CSI_FRAME_CTRL_LEN_CHECK_EN
        len_d         = len_q;
`endif
        dov_rise = bus.dec_output_valid_i && !dov_prev_q;
        // The decoder drops output_valid when the aligner stream stops, so a
        // falling data_valid_i also closes the line.
        line_end = !bus.dec_output_valid_i || (dv_prev_q && !bus.data_valid_i);

        case (state_q)
            ST_IDLE: begin
                if (bus.enable_i) state_d = ST_WAIT_FS;
            end
            ST_WAIT_FS: begin
                if (!bus.enable_i) begin
                    state_d = ST_IDLE;
                end else if (is_fs) begin
                    state_d       = ST_FRAME;
                    frame_start_d = 1'b1;
                    line_count_d  = '0;
                end else if (is_fe) begin
                    err_set[ERR_FE_NO_FS] = 1'b1;
                end
            end
            ST_FRAME: begin
                dec_en = bus.data_valid_i;
                if (is_fs) begin
                    err_set[ERR_FS_IN_FRAME] = 1'b1;
                    state_d = ST_DROP;
                end else if (is_fe) begin
                    frame_end_d = 1'b1;
                    if ((bus.expected_lines_i != 16'd0) &&
                        (line_count_q != bus.expected_lines_i)) begin
                        err_set[ERR_LINE_COUNT] = 1'b1;
                    end else begin
                        frame_count_d = frame_count_q + 16'd1;
                    end
                    state_d = bus.enable_i ? ST_WAIT_FS : ST_IDLE;
                end else if (dov_rise) begin
                    state_d      = ST_LINE;
                    line_valid_d = 1'b1;
`ifdef MIPI_CSI_FRAME_CTRL_LEN_CHECK_EN
                    if (line_count_q == 16'd0) begin
                        len_d = bus.dec_packet_length_i;
                    end else if (bus.dec_packet_length_i != len_q) begin
                        err_set[ERR_LINE_LEN] = 1'b1;
                        state_d      = ST_DROP;
                        line_valid_d = 1'b0;
                    end
`endif
                end
            end
            ST_LINE: begin
                dec_en = bus.data_valid_i;
                if (line_end) begin
                    if (line_count_q >= MAX_LINES) begin
                        err_set[ERR_LINE_LEN] = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        line_count_d = line_count_q + 16'd1;
                        state_d      = ST_FRAME;
                    end
                end else begin
                    line_valid_d = 1'b1;
                end
            end
            ST_DROP: begin
                // Let short packets reach the decoder so it stays in sync.
                dec_en = is_fs || is_fe;
                if (is_fe) state_d = ST_WAIT_FS;
            end
            default: state_d = ST_IDLE;
        endcase

        frame_valid_d = (state_d == ST_FRAME) || (state_d == ST_LINE);
        error_d       = (bus.error_clear_i ? 4'b0000 : error_q) | err_set;
    end

    // State and registered outputs; reset drops everything immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            frame_valid_q <= 1'b0;
            line_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            line_count_q  <= '0;
            frame_count_q <= '0;
            error_q       <= '0;
            dov_prev_q    <= 1'b0;
            dv_prev_q     <= 1'b0;
`ifdef MIPI_CSI_FRAME_CTRL_LEN_CHECK_EN
            len_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            frame_valid_q <= frame_valid_d;
            line_valid_q  <= line_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            line_count_q  <= line_count_d;
            frame_count_q <= frame_count_d;
            error_q       <= error_d;
            dov_prev_q    <= bus.dec_output_valid_i;
            dv_prev_q     <= bus.data_valid_i;
`ifdef MIPI_CSI_FRAME_CTRL_LEN_CHECK_EN
            len_q         <= len_d;
`endif
        end
    end

    // Output drive.
    always_comb begin
        bus.dec_enable_o  = dec_en;
        bus.frame_valid_o = frame_valid_q;
        bus.line_valid_o  = line_valid_q;
        bus.frame_start_o = frame_start_q;
        bus.frame_end_o   = frame_end_q;
        bus.line_count_o  = line_count_q;
        bus.frame_count_o = frame_count_q;
        bus.error_o       = error_q;
        bus.dbg_state_o   = state_q;
    end

endmodule

// File: tb/tb_mipi_csi_rx_frame_ctrl_16b2lane.sv
// Self-checking bench for the CSI-2 frame controller.
module tb_mipi_csi_rx_frame_ctrl_16b2lane;
    import mipi_csi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mipi_csi_rx_frame_ctrl_16b2lane_if bus ();

    mipi_csi_rx_frame_ctrl_16b2lane #(.MAX_LINES(16'd4096)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected line_valid_o burst lengths, in order.
    logic [15:0] exp_q[$];

    // ---------------- scoreboard monitor ----------------
    int run_len = 0;
    always @(negedge clk) begin
        if (reset_i) begin
            run_len = 0;
        end else if (bus.line_valid_o) begin
            run_len++;
        end else if (run_len != 0) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL line_burst: unexpected burst of %0d beats, none required", run_len);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (run_len[15:0] !== e) begin
                    tests_failed++;
                    $display("FAIL line_burst: got %0d beats, required %0d", run_len, e);
                end
            end
            run_len = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.data_valid_i       = 1'b0;
        bus.data_i             = '0;
        bus.dec_output_valid_i = 1'b0;
        bus.error_clear_i      = 1'b0;
    endtask

    task automatic send_short(input logic [7:0] dt);
        bus.data_valid_i = 1'b1;
        bus.data_i       = {$urandom_range(0, 65535), dt, SYNC_BYTE};
        step();
        bus.data_valid_i = 1'b0;
        bus.data_i       = '0;
    endtask

    // Drive one long-packet line; the beat count is bytes / 4 (two lanes of
    // 16-bit gear). Pushes the expected burst when it should be streamed.
    task automatic send_line(input logic [15:0] pkt_len, input bit expect_out);
        int beats;
        logic [31:0] d;
        beats = int'(pkt_len) / 4;
        if (expect_out) exp_q.push_back(beats[15:0]);
        for (int i = 0; i < beats; i++) begin
            d = $urandom;
            if (d[7:0] == SYNC_BYTE) d[7:0] = 8'h00;
            bus.data_valid_i        = 1'b1;
            bus.dec_output_valid_i  = 1'b1;
            bus.dec_packet_length_i = pkt_len;
            bus.data_i              = d;
            step();
        end
        bus.data_valid_i       = 1'b0;
        bus.dec_output_valid_i = 1'b0;
        bus.data_i             = '0;
        step();
    endtask

    task automatic clear_errors();
        bus.error_clear_i = 1'b1;
        step();
        bus.error_clear_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests_run++;
        if (bus.frame_valid_o !== 1'b0 || bus.line_valid_o !== 1'b0 ||
            bus.frame_start_o !== 1'b0 || bus.frame_end_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got fv=%b lv=%b fs=%b fe=%b, required all 0",
                     bus.frame_valid_o, bus.line_valid_o, bus.frame_start_o, bus.frame_end_o);
        end
        tests_run++;
        if (bus.line_count_o !== 16'd0 || bus.frame_count_o !== 16'd0 || bus.error_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_counts: got lc=%0d fc=%0d err=%b, required 0",
                     bus.line_count_o, bus.frame_count_o, bus.error_o);
        end
        tests_run++;
        if (bus.dbg_state_o !== ST_IDLE || bus.dec_enable_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got state=%0d dec_en=%b, required IDLE/0",
                     bus.dbg_state_o, bus.dec_enable_o);
        end
    endtask

    task automatic test_good_frame();
        bus.enable_i         = 1'b1;
        bus.expected_lines_i = 16'd4;
        step();
        send_short(DT_FRAME_START);
        tests_run++;
        if (bus.frame_start_o !== 1'b1 || bus.frame_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL fs_pulse: got fs=%b fv=%b, required 1/1", bus.frame_start_o, bus.frame_valid_o);
        end
        step();
        tests_run++;
        if (bus.frame_start_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL fs_single: frame_start_o=%b after 2 cycles, required 0", bus.frame_start_o);
        end
        // dec_enable_o must follow data_valid_i combinationally inside a frame.
        bus.data_valid_i = 1'b1;
        #1;
        tests_run++;
        if (bus.dec_enable_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL dec_enable_frame: got %b, required 1", bus.dec_enable_o);
        end
        bus.data_valid_i = 1'b0;
        for (int l = 0; l < 4; l++) send_line(16'h0A00, 1'b1);
        tests_run++;
        if (bus.line_count_o !== 16'd4) begin
            tests_failed++;
            $display("FAIL line_count: got %0d, required 4", bus.line_count_o);
        end
        send_short(DT_FRAME_END);
        tests_run++;
        if (bus.frame_end_o !== 1'b1 || bus.frame_valid_o !== 1'b0 ||
            bus.frame_count_o !== 16'd1 || bus.error_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL good_fe: got fe=%b fv=%b fc=%0d err=%b, required 1/0/1/0000",
                     bus.frame_end_o, bus.frame_valid_o, bus.frame_count_o, bus.error_o);
        end
        step();
    endtask

    task automatic test_fe_in_wait();
        send_short(DT_FRAME_END);
        tests_run++;
        if (bus.error_o !== 4'b0001 || bus.frame_end_o !== 1'b0 || bus.frame_count_o !== 16'd1) begin
            tests_failed++;
            $display("FAIL fe_no_fs: got err=%b fe=%b fc=%0d, required 0001/0/1",
                     bus.error_o, bus.frame_end_o, bus.frame_count_o);
        end
        clear_errors();
        tests_run++;
        if (bus.error_o !== 4'b0000) begin
            tests_failed++;
            $display("FAIL err_clear: got %b, required 0000", bus.error_o);
        end
        // Clear and a new error in the same cycle: the new error wins.
        bus.error_clear_i = 1'b1;
        send_short(DT_FRAME_END);
        bus.error_clear_i = 1'b0;
        tests_run++;
        if (bus.error_o !== 4'b0001) begin
            tests_failed++;
            $display("FAIL clear_vs_set: got %b, required 0001", bus.error_o);
        end
        clear_errors();
    endtask

    task automatic test_fs_in_frame();
        bus.expected_lines_i = 16'd2;
        send_short(DT_FRAME_START);
        send_line(16'h0010, 1'b1);
        send_line(16'h0010, 1'b1);
        send_short(DT_FRAME_START);
        tests_run++;
        if (bus.error_o !== 4'b0010 || bus.frame_valid_o !== 1'b0 || bus.dbg_state_o !== ST_DROP) begin
            tests_failed++;
            $display("FAIL fs_in_frame: got err=%b fv=%b state=%0d, required 0010/0/DROP",
                     bus.error_o, bus.frame_valid_o, bus.dbg_state_o);
        end
        bus.data_valid_i = 1'b1;
        #1;
        tests_run++;
        if (bus.dec_enable_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL dec_enable_drop: got %b, required 0", bus.dec_enable_o);
        end
        bus.data_valid_i = 1'b0;
        send_line(16'h0010, 1'b0);
        bus.data_valid_i = 1'b1;
        bus.data_i       = {16'h0000, DT_FRAME_END, SYNC_BYTE};
        #1;
        tests_run++;
        if (bus.dec_enable_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL dec_enable_drop_sp: got %b, required 1", bus.dec_enable_o);
        end
        step();
        bus.data_valid_i = 1'b0;
        bus.data_i       = '0;
        tests_run++;
        if (bus.frame_end_o !== 1'b0 || bus.dbg_state_o !== ST_WAIT_FS) begin
            tests_failed++;
            $display("FAIL drop_fe: got fe=%b state=%0d, required 0/WAIT_FS",
                     bus.frame_end_o, bus.dbg_state_o);
        end
        clear_errors();
        send_short(DT_FRAME_START);
        send_line(16'h0010, 1'b1);
        send_line(16'h0010, 1'b1);
        send_short(DT_FRAME_END);
        tests_run++;
        if (bus.frame_count_o !== 16'd2 || bus.error_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL after_drop: got fc=%0d err=%b, required 2/0000",
                     bus.frame_count_o, bus.error_o);
        end
        step();
    endtask

    task automatic test_line_count_mismatch();
        bus.expected_lines_i = 16'd3;
        send_short(DT_FRAME_START);
        send_line(16'h0014, 1'b1);
        send_line(16'h0014, 1'b1);
        send_short(DT_FRAME_END);
        tests_run++;
        if (bus.error_o !== 4'b0100 || bus.frame_end_o !== 1'b1 || bus.frame_count_o !== 16'd2) begin
            tests_failed++;
            $display("FAIL lines_mismatch: got err=%b fe=%b fc=%0d, required 0100/1/2",
                     bus.error_o, bus.frame_end_o, bus.frame_count_o);
        end
        step();
        clear_errors();
    endtask

    task automatic test_len_check();
        logic [3:0]  exp_err;
        logic [15:0] exp_fc;
        logic        exp_fe;
        bit          third_out;
`ifdef MIPI_CSI_FRAME_CTRL_LEN_CHECK_EN
        exp_err = 4'b1000; exp_fc = 16'd2; exp_fe = 1'b0; third_out = 1'b0;
`else
        exp_err = 4'b0000; exp_fc = 16'd3; exp_fe = 1'b1; third_out = 1'b1;
`endif
        bus.expected_lines_i = 16'd0;
        send_short(DT_FRAME_START);
        send_line(16'h0A00, 1'b1);
        send_line(16'h0A00, 1'b1);
        send_line(16'h0900, third_out);
        tests_run++;
        if (bus.error_o !== exp_err) begin
            tests_failed++;
            $display("FAIL len_check: got err=%b, required %b", bus.error_o, exp_err);
        end
        send_short(DT_FRAME_END);
        tests_run++;
        if (bus.frame_count_o !== exp_fc || bus.frame_end_o !== exp_fe) begin
            tests_failed++;
            $display("FAIL len_check_fe: got fc=%0d fe=%b, required %0d/%b",
                     bus.frame_count_o, bus.frame_end_o, exp_fc, exp_fe);
        end
        step();
        clear_errors();
    endtask

    task automatic test_reset_mid_line();
        bus.expected_lines_i = 16'd1;
        send_short(DT_FRAME_START);
        for (int i = 0; i < 3; i++) begin
            bus.data_valid_i        = 1'b1;
            bus.dec_output_valid_i  = 1'b1;
            bus.dec_packet_length_i = 16'h0020;
            bus.data_i              = 32'h1234_5600;
            step();
        end
        reset_i = 1'b1;
        #1;
        tests_run++;
        if (bus.frame_valid_o !== 1'b0 || bus.line_valid_o !== 1'b0 ||
            bus.line_count_o !== 16'd0 || bus.frame_count_o !== 16'd0 || bus.error_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got fv=%b lv=%b lc=%0d fc=%0d err=%b, required all 0",
                     bus.frame_valid_o, bus.line_valid_o, bus.line_count_o,
                     bus.frame_count_o, bus.error_o);
        end
        step();
        reset_i = 1'b0;
        step();
        idle_inputs();
        step();
        send_line(16'h0010, 1'b0);
        tests_run++;
        if (bus.line_count_o !== 16'd0 || bus.frame_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_fs_line: got lc=%0d fv=%b, required 0/0",
                     bus.line_count_o, bus.frame_valid_o);
        end
        send_short(DT_FRAME_START);
        send_line(16'h0010, 1'b1);
        send_short(DT_FRAME_END);
        tests_run++;
        if (bus.frame_count_o !== 16'd1 || bus.error_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL post_reset_frame: got fc=%0d err=%b, required 1/0000",
                     bus.frame_count_o, bus.error_o);
        end
        step();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset_i                 = 1'b1;
        bus.enable_i            = 1'b0;
        bus.dec_packet_length_i = '0;
        bus.expected_lines_i    = '0;
        idle_inputs();
        repeat (3) step();
        test_reset();
        reset_i = 1'b0;
        step();
        test_good_frame();
        test_fe_in_wait();
        test_fs_in_frame();
        test_line_count_mismatch();
        test_len_check();
        test_reset_mid_line();
        repeat (4) step();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d bursts still pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mipi_csi_rx_frame_ctrl_16b2lane.md
# mipi_csi_rx_frame_ctrl_16b2lane

Frame-level sequencer for the 2-lane, 16-bit-gear MIPI CSI-2 receive path. Sits beside the packet decoder on the lane-aligned byte-clock stream: it detects Frame Start/Frame End short packets, gates the decoder's input valid, and turns the decoder's per-line `output_valid` into frame/line framing for the downstream pixel unpacker and the USB FIFO writer. It also counts lines and frames and flags protocol errors, so a corrupted frame is dropped rather than streamed.

## Interface
Parameters:
- `MAX_LINES`, 16'd4096: line-count ceiling; exceeding it inside a frame is an error.

Ports:
- `clk_i`  in  1  MIPI byte clock (same domain as decoder)
- `reset_i`  in  1  asynchronous, active-high reset
- `enable_i`  in  1  run request; sampled only in IDLE and at frame boundaries
- `data_valid_i`  in  1  lane-aligner valid
- `data_i`  in  32  lane-aligned data; lane0 byte0 in [7:0]
- `dec_output_valid_i`  in  1  decoder `output_valid_o`
- `dec_packet_length_i`  in  16  decoder `packet_length_o`
- `expected_lines_i`  in  16  lines per frame; 0 disables the check
- `dec_enable_o`  out  1  gated `data_valid_i` fed to decoder
- `frame_valid_o`  out  1  high from FS to FE of an accepted frame
- `line_valid_o`  out  1  registered copy of `dec_output_valid_i` while in frame
- `frame_start_o`, `frame_end_o`  out  1  single-cycle pulses
- `line_count_o`  out  16  lines completed in current frame
- `frame_count_o`  out  16  good frames, wraps 0xFFFF→0
- `error_o`  out  4  sticky: [0] FE without FS, [1] FS inside frame, [2] line-count mismatch, [3] line-length mismatch/overflow
- `error_clear_i`  in  1  clears `error_o`

## Operation
- Short packet: `data_valid_i` && `data_i[7:0]==8'hB8` && `data_i[15:8]` = `8'h00` (FS) or `8'h01` (FE).
- States: IDLE, WAIT_FS, FRAME, LINE, DROP.
- IDLE: `dec_enable_o`=0. `enable_i`=1 → WAIT_FS.
- WAIT_FS: FS → FRAME, `frame_start_o` pulse, `line_count` cleared. FE → error[0], stay. `enable_i`=0 → IDLE.
- FRAME: `dec_enable_o`=`data_valid_i`. `dec_output_valid_i` rise → LINE. FE → compare `line_count` with `expected_lines_i` (if nonzero); mismatch → error[2], no `frame_count` increment; match → `frame_count`+1. Either way `frame_end_o` pulse and → WAIT_FS, or IDLE if `enable_i`=0. FS → error[1], → DROP.
- LINE: on `dec_output_valid_i` fall, `line_count`+1 and → FRAME. If `line_count` would exceed `MAX_LINES` → error[3], → DROP.
- DROP: `frame_valid_o`/`line_valid_o` forced 0, `dec_enable_o`=0 except during short-packet detection; next FE → WAIT_FS (no `frame_end_o`).
- `data_valid_i` falling while in LINE ends the line (decoder clears valid).
- Same-cycle `error_clear_i` and new error: the error bit is set.
- `line_count_o` saturates at `MAX_LINES`.

## Timing
- All outputs registered. Reset values: all 0, state IDLE.
- `frame_start_o`/`frame_valid_o` rise 1 cycle after the FS beat. `frame_end_o` pulses and `frame_valid_o` falls 1 cycle after the FE beat.
- `line_valid_o` lags `dec_output_valid_i` by 1 cycle. Downstream delays data by the same cycle.
- `dec_enable_o` is combinational from `data_valid_i` and the registered state. It adds 0 latency to the decoder path.
- Asserting reset mid-frame: all outputs drop immediately (async). The next frame requires a fresh FS.

## Configuration
- `MIPI_CSI_FRAME_CTRL_LEN_CHECK_EN`:
  - Defined: latch `dec_packet_length_i` of the first line in each frame. Any later line with a different length sets error[3] and goes to DROP.
  - Undefined: no length register; error[3] covers only `MAX_LINES` overflow.

## Structure
- The shared package `mipi_csi_pkg` holds:
  - `SYNC_BYTE`, `DT_FRAME_START`, `DT_FRAME_END`
  - the state enum
  - error-bit index constants
- One sub-module, `mipi_csi_short_pkt_detect`: a combinational FS/FE decode of the `data_i`/`data_valid_i` beat.

## Test plan
- Enable, FS, 4 lines of 0x0A00 bytes, FE with `expected_lines_i`=4 → `frame_start_o`, 4 `line_valid_o` bursts, `line_count_o`=4, `frame_count_o`=1, `error_o`=0.
- FE in WAIT_FS → `error_o`=4'b0001, no `frame_end_o`, `frame_count_o` unchanged.
- FS, 2 lines, FS → `error_o[1]`=1, DROP, `frame_valid_o`=0; FE → WAIT_FS; next good frame increments `frame_count_o`.
- `expected_lines_i`=3, frame with 2 lines → `error_o[2]`=1, `frame_end_o` pulses, `frame_count_o` not incremented.
- With the macro defined: line lengths 0x0A00, 0x0A00, 0x0900 → `error_o[3]`=1 on the third line, DROP. Without the macro → no error.
- `reset_i` pulse mid-LINE → all outputs 0 immediately. Lines before the next FS are ignored.
